ram_stream_reader: RTL and testbench

- Read-side engine for `dual_port_ram`: on a `start` pulse it reads `word_count` consecutive words beginning at `start_addr`.
- It owns the RAM's `raddr` port and absorbs the RAM's one-cycle registered read latency.
- Words are delivered over a valid/ready stream with a `last` marker, through a 2-entry skid buffer.
- Sits between the RAM read port and any consumer that can apply backpressure (DMA, UART TX, debug dump), complementing whatever writer fills the RAM.

---
 rtl/ram_stream_reader.sv | 154 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams word_count consecutive RAM words from start_addr over valid/ready through a 2-entry
// skid buffer. Define RAM_STREAM_READER_WRAP_EN to let requests wrap instead of being rejected.
module ram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, raddr_q;
  logic [ADDR_WIDTH:0]   cnt_q, issued_q;
  logic                  rd_pend_q, rd_last_q, done_q;
  logic [1:0]            buf_cnt_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;
  logic                  last0_q, last1_q;
  logic [2:0]            occ;
  logic                  pop, push, issue, idle_start, zero_req, accept, reject;

  assign idle_start = start && (state_q == StIdle);
  assign zero_req   = idle_start && (word_count == '0);
  assign accept     = idle_start && (word_count != '0) && !reject;

`ifdef RAM_STREAM_READER_WRAP_EN
  assign reject = 1'b0;
  assign error  = 1'b0;
`else
  localparam logic [ADDR_WIDTH+1:0] Depth = {2'b01, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH+1:0] req_end;
  logic                  error_q;

  assign req_end = {2'b00, start_addr} + {1'b0, word_count};
  assign reject  = idle_start && (word_count != '0) && (req_end > Depth);
  assign error   = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= reject;
  end
`endif

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = data0_q;
  assign m_last  = last0_q & m_valid;
  assign pop     = m_valid & m_ready;
  assign push    = rd_pend_q;
  assign done    = done_q;
  // Words already buffered or still in the RAM read pipeline.
  assign occ     = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  if (issue && (issued_q + 1'b1 == cnt_q)) state_d = StDrain;
      StDrain: if (pop && m_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue = (state_q == StRead) && (issued_q < cnt_q) && (occ < (3'd2 + {2'b00, pop}));
    raddr = issue ? addr_q : raddr_q;
    busy  = (state_q != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      issued_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      done_q    <= zero_req | ((state_q == StDrain) & pop & m_last);
      if (accept) begin
        addr_q   <= start_addr;
        cnt_q    <= word_count;
        issued_q <= '0;
      end
      if (issue) begin
        addr_q    <= addr_q + 1'b1;
        raddr_q   <= addr_q;
        issued_q  <= issued_q + 1'b1;
        rd_last_q <= (issued_q + 1'b1 == cnt_q);
      end
    end
  end

  // Skid buffer: entry 0 is the stream head, entry 1 holds the overflow word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_cnt_q <= 2'd0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt_q == 2'd0) begin
            data0_q <= ram_dout;
            last0_q <= rd_last_q;
          end else begin
            data1_q <= ram_dout;
            last1_q <= rd_last_q;
          end
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          data0_q   <= data1_q;
          last0_q   <= last1_q;
          buf_cnt_q <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            data0_q <= ram_dout;
            last0_q <= rd_last_q;
          end else begin
            data0_q <= data1_q;
            last0_q <= last1_q;
            data1_q <= ram_dout;
            last1_q <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: a behavioural RAM plus an arithmetic model of the
// expected word stream, done/error outcome and timing of each request.
module tb_ram_stream_reader;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_STREAM_READER_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] raddr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          error;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            done_cnt = 0;
  int            stall_bad = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .raddr     (raddr),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // One-cycle registered read, like dual_port_ram.
  always @(posedge clk) ram_dout <= mem[raddr];

  // Transfer monitor: inputs settle 1ns after posedge, so the negedge sees the upcoming edge.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (stall_prev && !reset && (!m_valid || m_data != prev_data || m_last != prev_last))
      stall_bad <= stall_bad + 1;
    stall_prev <= m_valid && !m_ready && !reset;
    prev_data  <= m_data;
    prev_last  <= m_last;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_last"},  64'(m_last),  64'd0);
    check_eq({tag, "_data"},  64'(m_data),  64'd0);
    check_eq({tag, "_busy"},  64'(busy),    64'd0);
    check_eq({tag, "_done"},  64'(done),    64'd0);
    check_eq({tag, "_error"}, 64'(error),   64'd0);
    check_eq({tag, "_raddr"}, 64'(raddr),   64'd0);
  endtask

  // Runs one request; rnd randomizes m_ready, poke re-pulses start while busy.
  task automatic run_req(input string tag, input int addr, input int cnt, input bit rnd,
                         input bit poke, input bit timing);
    int  base = rx_data.size();
    int  d0 = done_cnt;
    int  s0 = stall_bad;
    int  k = 1, first = -1, done_k = -1, last_pop_k = -1;
    bit  got_done = 0, got_err = 0, saw_valid = 0, saw_busy = 0, busy_at_done = 0;
    int  extra = 0;
    bit  exp_rej = !Wrap && (cnt != 0) && (addr + cnt > DEPTH);
    int  n_rx;
    logic [63:0] exp_word;

    start = 1'b1;
    start_addr = AW'(addr);
    word_count = (AW + 1)'(cnt);
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    start = 1'b0;
    while (k < 300 && !got_done && !got_err) begin
      if (m_valid) saw_valid = 1;
      if (m_valid && first < 0) first = k;
      if (busy) saw_busy = 1;
      if (error) got_err = 1;
      if (done) begin
        got_done = 1;
        done_k = k;
        busy_at_done = busy;
      end
      if (!got_done && !got_err) begin
        if (m_valid && m_ready && m_last) last_pop_k = k;
        start = poke && (k == 4);
        if (start) begin
          start_addr = 5'd0;
          word_count = 6'd3;
        end
        step();
        start = 1'b0;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        k++;
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || m_valid || busy) extra++;
    end
    n_rx = rx_data.size() - base;
    check_eq({tag, "_extra_activity"}, 64'(extra), 64'd0);
    check_eq({tag, "_done_count"}, 64'(done_cnt - d0), exp_rej ? 64'd0 : 64'd1);
    if (exp_rej) begin
      check_eq({tag, "_error"}, 64'(got_err), 64'd1);
      check_eq({tag, "_no_valid"}, 64'(saw_valid), 64'd0);
      check_eq({tag, "_no_busy"}, 64'(saw_busy), 64'd0);
    end else if (cnt == 0) begin
      check_eq({tag, "_zero_done_k"}, 64'(done_k), 64'd1);
      check_eq({tag, "_zero_no_valid"}, 64'(saw_valid), 64'd0);
      check_eq({tag, "_zero_no_err"}, 64'(got_err), 64'd0);
    end else begin
      check_eq({tag, "_done_seen"}, 64'(got_done), 64'd1);
      check_eq({tag, "_no_err"}, 64'(got_err), 64'd0);
      check_eq({tag, "_busy_falls"}, 64'(busy_at_done), 64'd0);
      check_eq({tag, "_done_after_last"}, 64'(done_k), 64'(last_pop_k + 1));
      check_eq({tag, "_words"}, 64'(n_rx), 64'(cnt));
      check_eq({tag, "_stable"}, 64'(stall_bad - s0), 64'd0);
      for (int i = 0; i < cnt && i < n_rx; i++) begin
        exp_word = {31'd0, (i == cnt - 1), mem[(addr + i) % DEPTH]};
        check_eq({tag, "_word"}, {31'd0, rx_last[base + i], rx_data[base + i]}, exp_word);
      end
      if (timing) begin
        check_eq({tag, "_first_valid"}, 64'(first), 64'd3);
        check_eq({tag, "_throughput"}, 64'(done_k - first), 64'(cnt));
      end
    end
  endtask

  initial begin
    int pops, k, d0;
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    word_count = '0;
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + 32'(i);
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    run_req("basic", 4, 8, 1'b0, 1'b0, 1'b1);
    run_req("backpressure", 4, 8, 1'b1, 1'b0, 1'b0);
    run_req("wrap", 30, 4, 1'b0, 1'b0, 1'b0);
    run_req("full_depth", 0, 32, 1'b0, 1'b0, 1'b1);
    run_req("full_depth_bp", 0, 32, 1'b1, 1'b0, 1'b0);
    run_req("zero", 7, 0, 1'b0, 1'b0, 1'b0);
    run_req("start_busy", 4, 8, 1'b1, 1'b1, 1'b0);

    // Abort a transfer with reset right after the third word leaves.
    d0 = done_cnt;
    start = 1'b1;
    start_addr = 5'd0;
    word_count = 6'd8;
    m_ready = 1'b1;
    step();
    start = 1'b0;
    pops = 0;
    k = 0;
    while (pops < 3 && k < 50) begin
      if (m_valid && m_ready) pops++;
      step();
      k++;
    end
    check_eq("abort_pops", 64'(pops), 64'd3);
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("abort_idle_valid", 64'(m_valid), 64'd0);
    run_req("after_abort", 0, 2, 1'b0, 1'b0, 1'b1);

    // Random contents, requests and backpressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int r = 0; r < 12; r++) begin
      run_req("random", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
              1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
